// File: rtl/cr_prng_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : cr_prng_sequencer_if
// Brief   : Controller, PRNG and consumer-stream signals of the CR PRNG sequencer
// Revision: 1.0 - initial release
// ============================================================================
interface cr_prng_sequencer_if #(
    parameter int CNT_W = 32
);
    typedef logic [CNT_W-1:0] cr_cnt_t;

    logic         start;
    cr_cnt_t      cnt_base;
    cr_cnt_t      num_blocks;
    logic [6:0]   prefix_in;
    logic         busy;
    logic         done;
    logic         ovf_err;

    logic [6:0]   prng_prefix;
    cr_cnt_t      prng_cnt;
    logic         prng_drdy;
    logic         prng_dvld;
    logic [255:0] prng_dout;

    logic [255:0] rnd_data;
    logic         rnd_vld;
    logic         rnd_rdy;

    modport slave (
        input  start, cnt_base, num_blocks, prefix_in, prng_dvld, prng_dout, rnd_rdy,
        output busy, done, ovf_err, prng_prefix, prng_cnt, prng_drdy, rnd_data, rnd_vld
    );

    modport master (
        output start, cnt_base, num_blocks, prefix_in, prng_dvld, prng_dout, rnd_rdy,
        input  busy, done, ovf_err, prng_prefix, prng_cnt, prng_drdy, rnd_data, rnd_vld
    );
endinterface
`default_nettype wire

// File: rtl/cr_prng_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cr_prng_sequencer
// Brief   : Issues credit-limited counter requests to the AES-CTR PRNG and buffers
//           the 256-bit results in an output FIFO on a valid/ready stream.
// Revision: 1.0 - initial release
// ============================================================================
module cr_prng_sequencer #(
    parameter int FIFO_DEPTH   = 16,
    parameter int MAX_INFLIGHT = 16,
    parameter int CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RST,
    cr_prng_sequencer_if.slave bus
);
    localparam int c_aw  = $clog2(FIFO_DEPTH);
    localparam int c_cw  = $clog2(FIFO_DEPTH + 1);
    localparam int c_iw  = $clog2(MAX_INFLIGHT + 1);
    localparam int c_ow  = $clog2(FIFO_DEPTH + MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt_base;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_received;
    logic [6:0]         r_prefix;
    logic [c_iw-1:0]    r_inflight;
    logic [c_cw-1:0]    r_count;
    logic [c_aw-1:0]    r_wptr;
    logic [c_aw-1:0]    r_rptr;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic [255:0]       r_mem [FIFO_DEPTH];

    logic [c_ow-1:0]    w_occupancy;
    logic               w_drdy;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_stray;
    logic               w_ret;
    logic               w_drained;

    // Every slot is either already in the FIFO or reserved by a request in flight.
    assign w_occupancy = c_ow'(r_count) + c_ow'(r_inflight);
    assign w_drdy      = (r_state == S_ISSUE) && (r_issued < r_num)
                       && (w_occupancy < c_ow'(FIFO_DEPTH))
                       && (r_inflight < c_iw'(MAX_INFLIGHT));
    assign w_pop       = (r_count != '0) && bus.rnd_rdy;
    assign w_full      = (r_count == c_cw'(FIFO_DEPTH));
    assign w_stray     = bus.prng_dvld && (r_inflight == '0);
    assign w_ret       = bus.prng_dvld && !w_stray;
    assign w_push      = w_ret && (!w_full || w_pop);
    assign w_drained   = (r_count == '0) || ((r_count == c_cw'(1)) && w_pop && !w_push);

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.prng_dout;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt_base <= '0;
            r_num      <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_prefix   <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_aw'(1);
            if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
            if (w_push && !w_pop)      r_count <= r_count + c_cw'(1);
            else if (!w_push && w_pop) r_count <= r_count - c_cw'(1);

            if (w_drdy && !w_ret)      r_inflight <= r_inflight + c_iw'(1);
            else if (!w_drdy && w_ret) r_inflight <= r_inflight - c_iw'(1);

            if (w_drdy) r_issued   <= r_issued + CNT_W'(1);
            if (w_ret)  r_received <= r_received + CNT_W'(1);

            // Results that arrive with nothing outstanding belong to an abandoned job.
            if (w_stray || (bus.prng_dvld && w_full && !w_pop)) r_ovf <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_cnt_base <= bus.cnt_base;
                        r_num      <= bus.num_blocks;
                        r_prefix   <= bus.prefix_in;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_busy     <= 1'b1;
                        if (bus.num_blocks == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_drdy && (r_issued + CNT_W'(1) == r_num)) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if ((r_received == r_num) && w_drained) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prng_prefix = r_prefix;
    assign bus.prng_cnt    = r_cnt_base + r_issued;
    assign bus.prng_drdy   = w_drdy;
    assign bus.rnd_vld     = (r_count != '0);
    assign bus.rnd_data    = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.ovf_err     = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_cr_prng_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cr_prng_sequencer
// Brief   : Randomized self-checking bench with a latency-queue PRNG model and
//           a counter-order reference for the delivered stream.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cr_prng_sequencer;
    localparam int W     = 32;
    localparam int DEPTH = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    cr_prng_sequencer_if #(.CNT_W(W)) bus  ();
    cr_prng_sequencer_if #(.CNT_W(W)) bus1 ();

    cr_prng_sequencer #(.FIFO_DEPTH(DEPTH), .MAX_INFLIGHT(16), .CNT_W(W)) dut (
        .CLK (CLK), .RST (RST), .bus (bus));
    cr_prng_sequencer #(.FIFO_DEPTH(DEPTH), .MAX_INFLIGHT(1), .CNT_W(W)) dut1 (
        .CLK (CLK), .RST (RST), .bus (bus1));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 10;
    int rdy_mode = 1;

    logic [W-1:0]  obs_cnt  [$];
    int            drdy_cyc [$];
    logic [255:0]  obs_data [$];
    int            pop_cyc  [$];
    int            done_cyc [$];
    int            busy_cycles;
    int            max_out;
    logic [W-1:0]  pend_cnt [$];
    logic [6:0]    pend_pfx [$];
    int            pend_due [$];

    function automatic logic [255:0] prng_f(input logic [6:0] p, input logic [W-1:0] c);
        return {c, ~c, c ^ 32'hDEADBEEF, {25'd0, p}, c + 32'd1, c * 32'd7, c ^ {p, 25'd0}, 32'h5A5A5A5A};
    endfunction

    task automatic clear_obs();
        obs_cnt.delete(); drdy_cyc.delete(); obs_data.delete(); pop_cyc.delete(); done_cyc.delete();
        pend_cnt.delete(); pend_pfx.delete(); pend_due.delete();
        busy_cycles = 0;
        max_out     = 0;
    endtask

    // One clock of PRNG model + consumer for the main instance; records observations only.
    task automatic run_cycle(input bit st);
        @(negedge CLK);
        cyc++;
        bus.start     = st;
        bus.prng_dvld = 1'b0;
        if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            bus.prng_dvld = 1'b1;
            bus.prng_dout = prng_f(pend_pfx[0], pend_cnt[0]);
            void'(pend_due.pop_front()); void'(pend_cnt.pop_front()); void'(pend_pfx.pop_front());
        end
        if (bus.prng_drdy) begin
            obs_cnt.push_back(bus.prng_cnt);
            drdy_cyc.push_back(cyc);
            pend_cnt.push_back(bus.prng_cnt);
            pend_pfx.push_back(bus.prng_prefix);
            pend_due.push_back(cyc + lat);
        end
        case (rdy_mode)
            0:       bus.rnd_rdy = 1'b0;
            1:       bus.rnd_rdy = 1'b1;
            default: bus.rnd_rdy = 1'($urandom_range(0, 1));
        endcase
        if (bus.rnd_vld && bus.rnd_rdy) begin
            obs_data.push_back(bus.rnd_data);
            pop_cyc.push_back(cyc);
        end
        if (bus.done) done_cyc.push_back(cyc);
        if (bus.busy) busy_cycles++;
        if (obs_cnt.size() - obs_data.size() > max_out) max_out = obs_cnt.size() - obs_data.size();
    endtask

    task automatic run_job(input logic [W-1:0] base, input int n, input logic [6:0] pfx,
                           input int budget, output int s_cyc, output bit to);
        clear_obs();
        bus.cnt_base   = base;
        bus.num_blocks = W'(n);
        bus.prefix_in  = pfx;
        run_cycle(1'b1);
        s_cyc = cyc;
        to    = 1'b1;
        for (int i = 0; i < budget; i++) begin
            run_cycle(1'b0);
            if (done_cyc.size() != 0) begin
                to = 1'b0;
                break;
            end
        end
        repeat (3) run_cycle(1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        n_tests++; if (bus.prng_drdy !== 1'b0) begin n_fail++; $display("FAIL rst_drdy: got %b exp 0", bus.prng_drdy); end
        n_tests++; if (bus.rnd_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b exp 0", bus.rnd_vld); end
        n_tests++; if (bus.rnd_data !== 256'd0) begin n_fail++; $display("FAIL rst_data: got %h exp 0", bus.rnd_data); end
        n_tests++; if ({bus.prng_cnt, bus.prng_prefix} !== 39'd0) begin n_fail++; $display("FAIL rst_cnt_pfx: got %h/%h exp 0", bus.prng_cnt, bus.prng_prefix); end
        n_tests++; if ({bus.busy, bus.done, bus.ovf_err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b exp 000", {bus.busy, bus.done, bus.ovf_err}); end
        n_tests++; if ({bus1.busy, bus1.prng_drdy, bus1.rnd_vld} !== 3'b000) begin n_fail++; $display("FAIL rst_dut1: got %b exp 000", {bus1.busy, bus1.prng_drdy, bus1.rnd_vld}); end
        RST = 1'b0;
        repeat (3) run_cycle(1'b0);
        n_tests++; if ({bus.busy, bus.prng_drdy, bus.rnd_vld} !== 3'b000) begin n_fail++; $display("FAIL idle_after_rst: got %b exp 000", {bus.busy, bus.prng_drdy, bus.rnd_vld}); end
    endtask

    task automatic test_basic();
        int s; bit to;
        lat = 10; rdy_mode = 1;
        run_job(32'd0, 4, 7'h15, 200, s, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b exp 0", to); end
        n_tests++; if (obs_cnt.size() != 4) begin n_fail++; $display("FAIL basic_nreq: got %0d exp 4", obs_cnt.size()); end
        for (int k = 0; k < obs_cnt.size() && k < 4; k++) begin
            n_tests++;
            if (obs_cnt[k] !== W'(k) || drdy_cyc[k] != s + 1 + k) begin
                n_fail++; $display("FAIL basic_req[%0d]: got cnt %0d @%0d exp cnt %0d @%0d", k, obs_cnt[k], drdy_cyc[k], k, s + 1 + k);
            end
        end
        n_tests++; if (obs_data.size() != 4) begin n_fail++; $display("FAIL basic_npop: got %0d exp 4", obs_data.size()); end
        for (int k = 0; k < obs_data.size() && k < 4; k++) begin
            n_tests++;
            if (obs_data[k] !== prng_f(7'h15, W'(k))) begin n_fail++; $display("FAIL basic_data[%0d]: got %h exp %h", k, obs_data[k], prng_f(7'h15, W'(k))); end
        end
        n_tests++;
        if (done_cyc.size() != 1 || pop_cyc.size() != 4 || done_cyc[0] != pop_cyc[3] + 1) begin
            n_fail++; $display("FAIL basic_done: got %0d pulses first @%0d exp 1 pulse one cycle after last pop", done_cyc.size(), (done_cyc.size() != 0) ? done_cyc[0] : -1);
        end
        n_tests++;
        if (done_cyc.size() == 0 || busy_cycles != done_cyc[0] - s) begin
            n_fail++; $display("FAIL basic_busy: got %0d cycles exp %0d", busy_cycles, (done_cyc.size() != 0) ? done_cyc[0] - s : -1);
        end
        n_tests++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b exp 0", bus.ovf_err); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] base; bit to;
        base = W'($urandom);
        lat = 10; rdy_mode = 0;
        clear_obs();
        bus.cnt_base = base; bus.num_blocks = W'(40); bus.prefix_in = 7'h2A;
        run_cycle(1'b1);
        repeat (60) run_cycle(1'b0);
        n_tests++; if (obs_cnt.size() != DEPTH) begin n_fail++; $display("FAIL bp_stall_nreq: got %0d exp %0d", obs_cnt.size(), DEPTH); end
        n_tests++; if ({bus.rnd_vld, bus.busy, bus.prng_drdy} !== 3'b110) begin n_fail++; $display("FAIL bp_stall_flags: got %b exp 110", {bus.rnd_vld, bus.busy, bus.prng_drdy}); end
        rdy_mode = 2;
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            run_cycle(1'b0);
            if (done_cyc.size() != 0) begin to = 1'b0; break; end
        end
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b exp 0", to); end
        n_tests++; if (obs_data.size() != 40 || obs_cnt.size() != 40) begin n_fail++; $display("FAIL bp_count: got %0d/%0d exp 40/40", obs_cnt.size(), obs_data.size()); end
        for (int k = 0; k < obs_data.size() && k < 40; k++) begin
            n_tests++;
            if (obs_data[k] !== prng_f(7'h2A, base + W'(k))) begin n_fail++; $display("FAIL bp_data[%0d]: got %h exp %h", k, obs_data[k], prng_f(7'h2A, base + W'(k))); end
        end
        n_tests++; if (max_out > DEPTH) begin n_fail++; $display("FAIL bp_credit: got %0d outstanding exp <= %0d", max_out, DEPTH); end
        n_tests++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL bp_ovf: got %b exp 0", bus.ovf_err); end
        repeat (2) run_cycle(1'b0);
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_w [4];
        int s; bit to;
        exp_w = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        lat = 4; rdy_mode = 1;
        run_job(32'hFFFF_FFFE, 4, 7'h01, 200, s, to);
        n_tests++; if (to !== 1'b0 || obs_cnt.size() != 4) begin n_fail++; $display("FAIL wrap_job: got timeout %b nreq %0d exp 0/4", to, obs_cnt.size()); end
        for (int k = 0; k < obs_cnt.size() && k < 4; k++) begin
            n_tests++;
            if (obs_cnt[k] !== exp_w[k]) begin n_fail++; $display("FAIL wrap_cnt[%0d]: got %h exp %h", k, obs_cnt[k], exp_w[k]); end
        end
        n_tests++;
        if (obs_data.size() != 4 || obs_data[3] !== prng_f(7'h01, 32'h1)) begin n_fail++; $display("FAIL wrap_data: got %0d pops exp 4 ending with cnt 1", obs_data.size()); end
    endtask

    task automatic test_zero_and_ignore();
        int s; bit to;
        logic [W-1:0] b1;
        lat = 6; rdy_mode = 1;
        run_job(32'h1234, 0, 7'h33, 20, s, to);
        n_tests++; if (obs_cnt.size() != 0) begin n_fail++; $display("FAIL zero_drdy: got %0d requests exp 0", obs_cnt.size()); end
        n_tests++; if (busy_cycles != 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles exp 1", busy_cycles); end
        n_tests++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 1) begin n_fail++; $display("FAIL zero_done: got %0d pulses first @%0d exp 1 @%0d", done_cyc.size(), (done_cyc.size() != 0) ? done_cyc[0] : -1, s + 1); end

        b1 = W'($urandom);
        clear_obs();
        bus.cnt_base = b1; bus.num_blocks = W'(6); bus.prefix_in = 7'h44;
        run_cycle(1'b1);
        repeat (3) run_cycle(1'b0);
        bus.cnt_base = b1 + 32'd1000; bus.num_blocks = W'(9); bus.prefix_in = 7'h55;
        run_cycle(1'b1);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            run_cycle(1'b0);
            if (done_cyc.size() != 0) begin to = 1'b0; break; end
        end
        repeat (4) run_cycle(1'b0);
        n_tests++; if (to !== 1'b0 || obs_cnt.size() != 6 || obs_data.size() != 6) begin n_fail++; $display("FAIL ignore_count: got %0d req %0d pops exp 6/6", obs_cnt.size(), obs_data.size()); end
        for (int k = 0; k < obs_data.size() && k < 6; k++) begin
            n_tests++;
            if (obs_data[k] !== prng_f(7'h44, b1 + W'(k))) begin n_fail++; $display("FAIL ignore_data[%0d]: got %h exp %h", k, obs_data[k], prng_f(7'h44, b1 + W'(k))); end
        end
        n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL ignore_done: got %0d pulses exp 1", done_cyc.size()); end
    endtask

    task automatic test_random();
        int s; bit to; int n; logic [W-1:0] base; logic [6:0] pfx;
        for (int j = 0; j < 6; j++) begin
            lat = $urandom_range(1, 12); rdy_mode = 2;
            n = $urandom_range(1, 30); base = W'($urandom); pfx = 7'($urandom);
            run_job(base, n, pfx, 3000, s, to);
            n_tests++;
            if (to !== 1'b0 || obs_cnt.size() != n || obs_data.size() != n) begin
                n_fail++; $display("FAIL rnd%0d_count: got timeout %b req %0d pops %0d exp 0/%0d/%0d", j, to, obs_cnt.size(), obs_data.size(), n, n);
            end
            for (int k = 0; k < obs_data.size() && k < n; k++) begin
                n_tests++;
                if (obs_cnt[k] !== base + W'(k) || obs_data[k] !== prng_f(pfx, base + W'(k))) begin
                    n_fail++; $display("FAIL rnd%0d_item[%0d]: got cnt %h data %h exp cnt %h", j, k, obs_cnt[k], obs_data[k], base + W'(k));
                end
            end
            n_tests++;
            if (done_cyc.size() != 1 || pop_cyc.size() == 0 || done_cyc[0] != pop_cyc[pop_cyc.size()-1] + 1) begin
                n_fail++; $display("FAIL rnd%0d_done: got %0d pulses exp 1 after last pop", j, done_cyc.size());
            end
            n_tests++;
            if (max_out > DEPTH || bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_credit: got out %0d ovf %b exp <=%0d/0", j, max_out, bus.ovf_err, DEPTH); end
        end
    endtask

    task automatic test_max_inflight1();
        int q_due [$]; logic [W-1:0] q_cnt [$];
        int d_cyc [$]; int v_cyc [$]; logic [W-1:0] c_obs [$]; logic [255:0] r_obs [$];
        int s; int dn; int mx; bit to;
        dn = 0; mx = 0; to = 1'b1;
        @(negedge CLK); cyc++;
        bus1.cnt_base = 32'h100; bus1.num_blocks = W'(3); bus1.prefix_in = 7'h0F; bus1.start = 1'b1;
        s = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK); cyc++;
            bus1.start = 1'b0; bus1.prng_dvld = 1'b0;
            if (q_due.size() != 0 && q_due[0] <= cyc) begin
                bus1.prng_dvld = 1'b1; bus1.prng_dout = prng_f(7'h0F, q_cnt[0]);
                v_cyc.push_back(cyc); void'(q_due.pop_front()); void'(q_cnt.pop_front());
            end
            if (bus1.prng_drdy) begin
                d_cyc.push_back(cyc); c_obs.push_back(bus1.prng_cnt);
                q_due.push_back(cyc + 3); q_cnt.push_back(bus1.prng_cnt);
            end
            if (d_cyc.size() - v_cyc.size() > mx) mx = d_cyc.size() - v_cyc.size();
            if (bus1.rnd_vld) r_obs.push_back(bus1.rnd_data);
            if (bus1.done) begin dn++; to = 1'b0; break; end
        end
        n_tests++; if (to !== 1'b0 || d_cyc.size() != 3) begin n_fail++; $display("FAIL mi1_count: got timeout %b req %0d exp 0/3", to, d_cyc.size()); end
        n_tests++; if (mx > 1) begin n_fail++; $display("FAIL mi1_outstanding: got %0d exp <= 1", mx); end
        n_tests++; if (d_cyc.size() == 0 || d_cyc[0] != s + 1) begin n_fail++; $display("FAIL mi1_first: got @%0d exp @%0d", (d_cyc.size() != 0) ? d_cyc[0] : -1, s + 1); end
        for (int k = 1; k < d_cyc.size() && k < 3 && k <= v_cyc.size(); k++) begin
            n_tests++;
            if (d_cyc[k] != v_cyc[k-1] + 1 || c_obs[k] !== 32'h100 + W'(k)) begin
                n_fail++; $display("FAIL mi1_req[%0d]: got cnt %h @%0d exp cnt %h @%0d", k, c_obs[k], d_cyc[k], 32'h100 + W'(k), v_cyc[k-1] + 1);
            end
        end
        n_tests++;
        if (r_obs.size() != 3 || r_obs[2] !== prng_f(7'h0F, 32'h102)) begin n_fail++; $display("FAIL mi1_data: got %0d pops exp 3 ending with cnt 102", r_obs.size()); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset_midjob();
        bit to;
        lat = 10; rdy_mode = 1;
        clear_obs();
        bus.cnt_base = 32'h500; bus.num_blocks = W'(20); bus.prefix_in = 7'h66;
        run_cycle(1'b1);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            run_cycle(1'b0);
            if (obs_cnt.size() == 5) begin to = 1'b0; break; end
        end
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_setup: got timeout %b exp 0", to); end
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        n_tests++;
        if ({bus.prng_drdy, bus.busy, bus.rnd_vld, bus.done, bus.ovf_err} !== 5'b0 || {bus.prng_cnt, bus.prng_prefix} !== 39'd0) begin
            n_fail++; $display("FAIL rstmid_async: got flags %b cnt %h pfx %h exp all 0", {bus.prng_drdy, bus.busy, bus.rnd_vld, bus.done, bus.ovf_err}, bus.prng_cnt, bus.prng_prefix);
        end
        @(negedge CLK); bus.prng_dvld = 1'b0;
        @(negedge CLK); RST = 1'b0;
        n_tests++; if (bus.ovf_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf_pre: got %b exp 0", bus.ovf_err); end
        repeat (25) run_cycle(1'b0);
        n_tests++; if (pend_due.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d pending exp 0", pend_due.size()); end
        n_tests++; if (bus.ovf_err !== 1'b1) begin n_fail++; $display("FAIL rstmid_ovf: got %b exp 1", bus.ovf_err); end
        n_tests++; if ({bus.rnd_vld, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: got %b exp 00", {bus.rnd_vld, bus.busy}); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.cnt_base = '0; bus.num_blocks = '0; bus.prefix_in = '0;
        bus.prng_dvld = 1'b0; bus.prng_dout = '0; bus.rnd_rdy = 1'b0;
        bus1.start = 1'b0; bus1.cnt_base = '0; bus1.num_blocks = '0; bus1.prefix_in = '0;
        bus1.prng_dvld = 1'b0; bus1.prng_dout = '0; bus1.rnd_rdy = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_and_ignore();
        test_random();
        test_max_inflight1();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
